// File: rtl/layer_mixer_if.sv
// Bundles the layer-mixer video, layer-pixel, fade-control and VGA pin signals.
// Latency: none, wires only.
// Backpressure: none; the video stream is free-running.
interface layer_mixer_if #(
    parameter int NUM_FG = 3
);
    logic                    hsync_in;
    logic                    vsync_in;
    logic                    valid_in;
    logic [11:0]             bg_pixel;
    logic [NUM_FG*12-1:0]    fg_pixel;
    logic [1:0]              fade_cmd;
    logic                    fade_cmd_valid;
    logic                    fade_busy;
    logic [3:0]              vga_r;
    logic [3:0]              vga_g;
    logic [3:0]              vga_b;
    logic                    hsync_out;
    logic                    vsync_out;

    // Upstream side: timing generator, layer generators and fade controller.
    modport master (
        output hsync_in, vsync_in, valid_in, bg_pixel, fg_pixel,
        output fade_cmd, fade_cmd_valid,
        input  fade_busy, vga_r, vga_g, vga_b, hsync_out, vsync_out
    );

    // Mixer side.
    modport slave (
        input  hsync_in, vsync_in, valid_in, bg_pixel, fg_pixel,
        input  fade_cmd, fade_cmd_valid,
        output fade_busy, vga_r, vga_g, vga_b, hsync_out, vsync_out
    );
endinterface

// File: rtl/layer_mixer.sv
// Priority layer select with a colour key, then a frame-synchronous brightness fade.
// Latency: pixel-to-pin 2 cycles; sync-to-pin LAYER_LAT+2 cycles.
// Backpressure: none; the video stream never stalls, and fade commands are dropped while busy.
module layer_mixer #(
    parameter int          NUM_FG           = 3,
    parameter int          LAYER_LAT        = 1,
    parameter logic [11:0] TRANSPARENT      = 12'hF0F,
    parameter int          FADE_STEP_FRAMES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    layer_mixer_if.slave  bus
);
    localparam int          SYNC_D = LAYER_LAT + 2;
    // Valid is consumed at stage 2, one tap before the pins, so it needs one tap fewer.
    localparam int          VLD_D  = LAYER_LAT + 1;
    localparam logic [7:0]  STEP   = 8'(FADE_STEP_FRAMES);

    typedef enum logic [1:0] {IDLE, FADE_IN, FADE_OUT} state_t;

    logic [SYNC_D-1:0] hs_tap;
    logic [SYNC_D-1:0] vs_tap;
    logic [VLD_D-1:0]  vld_tap;
    logic              vs_prev;
    logic              frame_tick;
    logic [11:0]       sel_pix;
    logic [11:0]       sel_q;
    logic [3:0]        r_q, g_q, b_q;
    state_t            state_q, state_d;
    logic [4:0]        level_q, level_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              busy_q;

    // One colour channel scaled by level/16; level 16 is unity, level 0 is black.
    function automatic logic [3:0] scale(input logic [3:0] c, input logic [4:0] lvl);
        return 4'(({5'b0, c} * {4'b0, lvl}) >> 4);
    endfunction

    assign frame_tick = !bus.vsync_in && vs_prev;

    // Delay syncs and valid so they line up with the pixel pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_tap  <= '1;
            vs_tap  <= '1;
            vld_tap <= '0;
            vs_prev <= 1'b1;
        end else begin
            hs_tap[0]  <= bus.hsync_in;
            vs_tap[0]  <= bus.vsync_in;
            vld_tap[0] <= bus.valid_in;
            for (int i = 1; i < SYNC_D; i++) begin
                hs_tap[i] <= hs_tap[i-1];
                vs_tap[i] <= vs_tap[i-1];
            end
            for (int i = 1; i < VLD_D; i++) begin
                vld_tap[i] <= vld_tap[i-1];
            end
            vs_prev <= bus.vsync_in;
        end
    end

    // Lowest-index opaque foreground layer wins; background is never keyed.
    always_comb begin
        sel_pix = bus.bg_pixel;
        for (int k = NUM_FG - 1; k >= 0; k--) begin
            if (bus.fg_pixel[12*k +: 12] != TRANSPARENT) begin
                sel_pix = bus.fg_pixel[12*k +: 12];
            end
        end
    end

    // Stage 1 registers the selection; stage 2 applies fade and blanking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= '0;
            r_q   <= '0;
            g_q   <= '0;
            b_q   <= '0;
        end else begin
            sel_q <= sel_pix;
            if (vld_tap[LAYER_LAT]) begin
                r_q <= scale(sel_q[11:8], level_q);
                g_q <= scale(sel_q[7:4],  level_q);
                b_q <= scale(sel_q[3:0],  level_q);
            end else begin
                r_q <= '0;
                g_q <= '0;
                b_q <= '0;
            end
        end
    end

    // Fade state, brightness level, frame counter and busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            level_q <= 5'd16;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    // Command acceptance and per-tick level stepping; the level only moves on frame ticks.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.fade_cmd_valid) begin
                    if (bus.fade_cmd == 2'b01 && level_q < 5'd16) begin
                        state_d = FADE_IN;
                        cnt_d   = '0;
                    end else if (bus.fade_cmd == 2'b10 && level_q != 5'd0) begin
                        state_d = FADE_OUT;
                        cnt_d   = '0;
                    end
                end
            end
            FADE_IN: begin
                if (frame_tick) begin
                    if (cnt_q + 8'd1 == STEP) begin
                        cnt_d   = '0;
                        level_d = level_q + 5'd1;
                        if (level_q == 5'd15) state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            FADE_OUT: begin
                if (frame_tick) begin
                    if (cnt_q + 8'd1 == STEP) begin
                        cnt_d   = '0;
                        level_d = level_q - 5'd1;
                        if (level_q == 5'd1) state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.vga_r     = r_q;
    assign bus.vga_g     = g_q;
    assign bus.vga_b     = b_q;
    assign bus.hsync_out = hs_tap[SYNC_D-1];
    assign bus.vsync_out = vs_tap[SYNC_D-1];
    assign bus.fade_busy = busy_q;
endmodule

// File: doc/layer_mixer.md
Name: layer_mixer

Overview:
- Downstream consumer of the per-layer pixel generators (background layer plus foreground sprite/text layers).
- Each cycle it selects the highest-priority non-transparent layer pixel and applies a global frame-synchronous brightness fade.
- Aligns hsync/vsync/video-valid with the pixel pipeline.
- Drives the 4/4/4 VGA output pins directly.

Parameters:
- NUM_FG, 3: number of foreground layers; fg layer 0 has the highest priority.
- LAYER_LAT, 1: clock latency from h_cnt/v_cnt to the layer pixel outputs (BRAM read latency); must be 0..4.
- TRANSPARENT, 12'hF0F: colour key marking a foreground pixel as transparent.
- FADE_STEP_FRAMES, 4: frame ticks per one-unit brightness step; must be 1..255.

Ports:
- clk  in  1  pixel clock (25 MHz)
- rst_n  in  1  asynchronous active-low reset
- hsync_in  in  1  horizontal sync from the VGA controller, active low, aligned with h_cnt
- vsync_in  in  1  vertical sync from the VGA controller, active low, aligned with v_cnt
- valid_in  in  1  active-video flag, aligned with h_cnt/v_cnt
- bg_pixel  in  12  background layer pixel {R,G,B}, arrives LAYER_LAT cycles after its counters
- fg_pixel  in  NUM_FG*12  foreground pixels; layer k occupies bits [12k+11:12k]; same timing as bg_pixel
- fade_cmd  in  2  2'b01 = fade in, 2'b10 = fade out, others = no-op
- fade_cmd_valid  in  1  one-cycle command strobe
- fade_busy  out  1  high while a fade is in progress
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue
- hsync_out  out  1  delayed hsync_in
- vsync_out  out  1  delayed vsync_in

Behaviour:
- Reset (asynchronous, rst_n low):
  - vga_r/g/b = 0.
  - hsync_out = vsync_out = 1.
  - fade_busy = 0.
  - All sync/valid delay taps are set to their inactive values (sync 1, valid 0).
  - Fade level = 16.
  - FSM = IDLE.
  - Frame counter = 0.
- Sync alignment: hsync_in, vsync_in and valid_in pass through a shift register of depth LAYER_LAT+2. Sync-to-pin latency is therefore LAYER_LAT+2 cycles, and pixel-to-pin latency is 2 cycles.
- Stage 1 (registered select):
  - Result is the lowest-index fg layer whose pixel != TRANSPARENT.
  - If all fg layers are transparent, the result is bg_pixel.
  - bg_pixel is never keyed.
- Stage 2 (registered fade): each channel out = (c * level) >> 4, where c is 4 bits, level is 5 bits (0..16), and the product is 9 bits; the output takes product bits [7:4].
  - level 16 gives out = c.
  - level 0 gives out = 0.
- Blanking: when the delayed valid tap is 0 at stage 2, vga_r/g/b = 0 regardless of the selected pixel.
- Frame tick: the single cycle where vsync_in is 0 and its registered previous value is 1 (falling edge).
- Fade FSM states are IDLE, FADE_IN and FADE_OUT.
- In IDLE, when fade_cmd_valid is high:
  - 01 with level < 16: go to FADE_IN, clear the frame counter.
  - 10 with level > 0: go to FADE_OUT, clear the frame counter.
  - 01 with level = 16, or 10 with level = 0: stay IDLE, no busy pulse.
  - Other codes: ignored.
- While in FADE_IN or FADE_OUT, any fade_cmd_valid is ignored (not queued).
- Level stepping:
  - The frame counter increments on each frame tick.
  - When the frame counter reaches FADE_STEP_FRAMES on a tick, it clears and the level steps by +1 (FADE_IN) or -1 (FADE_OUT).
  - Level changes only on frame ticks, so there is no mid-frame tearing.
- Fade completion: on the same edge where level reaches 16 (FADE_IN) or 0 (FADE_OUT), the FSM returns to IDLE.
- fade_busy = (state != IDLE), registered.
- Level is held while IDLE; the last fade result persists indefinitely.
- A frame tick coinciding with command acceptance does not count toward the first step.
- Reset asserted mid-fade returns immediately to the reset values: level 16 and full brightness.

Test Plan:
- Priority: fg0 = F0F, fg1 = 0A0, fg2 = 00F, bg = 123, valid high, level 16 -> after 2 cycles rgb = 0,A,0. With all fg = F0F -> rgb = 1,2,3.
- Latency/sync: LAYER_LAT = 1, single-cycle hsync_in low pulse at cycle 10 -> hsync_out low exactly at cycle 13. Pixel presented at cycle 11 appears at cycle 13.
- Blanking: valid_in low, bg = FFF -> rgb = 0,0,0 at the aligned output cycle.
- Fade out: FADE_STEP_FRAMES = 4, pixel FFF, cmd 10 accepted:
  - after 4 frame ticks level = 15 and rgb = E,E,E;
  - after 64 ticks level = 0, rgb = 0,0,0 and fade_busy falls on that tick edge.
- Command rules:
  - fade-in cmd issued mid fade-out -> ignored, level keeps decreasing;
  - fade-out cmd at level 0 -> fade_busy stays 0.
- Reset mid-fade at level 9 -> outputs 0, syncs 1, busy 0 immediately; after release, pixel FFF shows as F,F,F.
